// File: rtl/bus_nx_monitor.sv
// Non-existent memory/device monitor: times bus ACKs per request, stalls the CPU
// while waiting, and records timeouts as sticky per-channel flags plus a count.
module bus_nx_monitor #(
  parameter  int NCHAN   = 2,
  parameter  int ADDR_W  = 36,
  parameter  int TIMEOUT = 64,
  parameter  int CNT_W   = 8,
  localparam int CHW     = (NCHAN > 1) ? $clog2(NCHAN) : 1,
  localparam int TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqVALID,
  input  logic [CHW-1:0]    reqCHAN,
  input  logic [ADDR_W-1:0] reqADDR,
  input  logic              ackI,
  input  logic [NCHAN-1:0]  nxCLR,
  input  logic              cntCLR,
  output logic              busWAIT,
  output logic              busBUSY,
  output logic [NCHAN-1:0]  nxINTR,
  output logic [ADDR_W-1:0] nxADDR,
  output logic [CNT_W-1:0]  nxCOUNT,
  output logic              strayACK
);

  typedef enum logic [1:0] {IDLE, WAIT, FAIL} state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [CHW-1:0]      chan_q, chan_d;
  logic [ADDR_W-1:0]   laddr_q, laddr_d;
  logic [NCHAN-1:0]    intr_q, intr_d;
  logic [ADDR_W-1:0]   nxaddr_q, nxaddr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                armed_q, armed_d;
  logic                stray_q, stray_d;
  logic                fail_set;
  logic [CHW-1:0]      req_chan;

  // Out-of-range channel numbers fold onto the last channel
  assign req_chan = (int'(reqCHAN) >= NCHAN) ? CHW'(NCHAN - 1) : reqCHAN;

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    chan_d   = chan_q;
    laddr_d  = laddr_q;
    stray_d  = 1'b0;
    fail_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (reqVALID && !ackI) begin
          state_d = WAIT;
          tmr_d   = TW'(TIMEOUT - 1);
          chan_d  = req_chan;
          laddr_d = reqADDR;
        end else if (ackI && !reqVALID) begin
          stray_d = 1'b1;
        end
      end
      WAIT: begin
        if (ackI) begin
          state_d = IDLE;
        end else if (tmr_q == '0) begin
          state_d  = FAIL;
          fail_set = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      FAIL: begin
        state_d = IDLE;
        stray_d = ackI;
      end
      default: state_d = IDLE;
    endcase
  end

  // Set beats clear when both hit one channel in the same cycle
  for (genvar i = 0; i < NCHAN; i++) begin : g_intr
    assign intr_d[i] = (intr_q[i] & ~nxCLR[i]) | (fail_set && (chan_q == CHW'(i)));
  end

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    cnt_d    = cnt_q;
    armed_d  = armed_q;
    nxaddr_d = nxaddr_q;
    if (fail_set) begin
      cnt_d = cntCLR ? CNT_W'(1) : cnt_inc;
      if (armed_q || cntCLR) begin
        nxaddr_d = laddr_q;
        armed_d  = 1'b0;
      end
    end else if (cntCLR) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      chan_q   <= '0;
      laddr_q  <= '0;
      intr_q   <= '0;
      nxaddr_q <= '0;
      cnt_q    <= '0;
      armed_q  <= 1'b1;
      stray_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      chan_q   <= chan_d;
      laddr_q  <= laddr_d;
      intr_q   <= intr_d;
      nxaddr_q <= nxaddr_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      stray_q  <= stray_d;
    end
  end

  assign busWAIT  = ((state_q == IDLE) && reqVALID && !ackI) || (state_q == WAIT);
  assign busBUSY  = (state_q == WAIT);
  assign nxINTR   = intr_q;
  assign nxADDR   = nxaddr_q;
  assign nxCOUNT  = cnt_q;
  assign strayACK = stray_q;

endmodule

// File: tb/tb_bus_nx_monitor.sv
// Directed plus random bench for bus_nx_monitor against an elapsed-time model.
module tb_bus_nx_monitor;
  localparam int NCHAN = 2, ADDR_W = 36, TIMEOUT = 4, CNT_W = 2;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              reqVALID;
  logic [0:0]        reqCHAN;
  logic [ADDR_W-1:0] reqADDR;
  logic              ackI;
  logic [NCHAN-1:0]  nxCLR;
  logic              cntCLR;
  logic              busWAIT, busBUSY, strayACK;
  logic [NCHAN-1:0]  nxINTR;
  logic [ADDR_W-1:0] nxADDR;
  logic [CNT_W-1:0]  nxCOUNT;

  bus_nx_monitor #(.NCHAN(NCHAN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .reqVALID(reqVALID), .reqCHAN(reqCHAN), .reqADDR(reqADDR),
    .ackI(ackI), .nxCLR(nxCLR), .cntCLR(cntCLR), .busWAIT(busWAIT), .busBUSY(busBUSY),
    .nxINTR(nxINTR), .nxADDR(nxADDR), .nxCOUNT(nxCOUNT), .strayACK(strayACK));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Model: a transaction is described by its start cycle; it times out when
  // TIMEOUT cycles have elapsed without an ACK.
  int                cyc = 0;
  bit                m_pend, m_fail, m_armed, m_stray;
  int                m_t0, m_chan, m_cnt;
  logic [ADDR_W-1:0] m_paddr, m_addr;
  logic [NCHAN-1:0]  m_intr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_fail = 0; m_armed = 1; m_stray = 0;
    m_t0 = 0; m_chan = 0; m_cnt = 0; m_paddr = '0; m_addr = '0; m_intr = '0;
  endtask

  task automatic step(input bit r, input bit rq, input int ch, input logic [ADDR_W-1:0] a,
                      input bit ak, input logic [NCHAN-1:0] nc, input bit cc);
    bit fail_now, idle;
    @(negedge clk);
    rst = r; reqVALID = rq; reqCHAN = 1'(ch); reqADDR = a; ackI = ak; nxCLR = nc; cntCLR = cc;
    #1;
    idle = !m_pend && !m_fail;
    chk("busWAIT",  64'(busWAIT),  64'(m_pend || (idle && rq && !ak)));
    chk("busBUSY",  64'(busBUSY),  64'(m_pend));
    chk("nxINTR",   64'(nxINTR),   64'(m_intr));
    chk("nxADDR",   64'(nxADDR),   64'(m_addr));
    chk("nxCOUNT",  64'(nxCOUNT),  64'(m_cnt));
    chk("strayACK", 64'(strayACK), 64'(m_stray));
    @(posedge clk);
    if (r) model_reset();
    else begin
      fail_now = m_pend && !ak && (cyc - m_t0 == TIMEOUT);
      m_stray  = ak && !m_pend && (m_fail || !rq);
      m_intr   = m_intr & ~nc;
      if (cc) begin m_cnt = 0; m_armed = 1; end
      if (fail_now) begin
        m_intr[m_chan] = 1'b1;
        m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        if (m_armed) begin m_addr = m_paddr; m_armed = 0; end
      end
      if (m_pend && (ak || fail_now)) m_pend = 0;
      else if (idle && rq && !ak) begin
        m_pend = 1; m_t0 = cyc; m_chan = (ch >= NCHAN) ? NCHAN - 1 : ch; m_paddr = a;
      end
      m_fail = fail_now;
    end
    cyc++;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, '0, 0);
  endtask

  task automatic req(input int ch, input logic [ADDR_W-1:0] a);
    step(0, 1, ch, a, 0, '0, 0);
  endtask

  initial begin
    logic [63:0] rnd;
    rst = 1; reqVALID = 0; reqCHAN = '0; reqADDR = '0; ackI = 0; nxCLR = '0; cntCLR = 0;
    repeat (2) @(posedge clk);
    model_reset();
    step(1, 0, 0, '0, 0, '0, 0);
    idle_n(1);

    // 1: ack at t+2
    req(0, 36'h000001234); idle_n(1); step(0, 0, 0, '0, 1, '0, 0); idle_n(1);
    chk("t1_intr", 64'(nxINTR), 64'd0);
    // 2: timeout on chan1
    req(1, 36'h200000400); idle_n(5);
    chk("t2_intr", 64'(nxINTR), 64'h2);
    chk("t2_addr", 64'(nxADDR), 64'h200000400);
    chk("t2_cnt",  64'(nxCOUNT), 64'd1);
    // 3: second timeout, no recapture, then clear chan0
    req(0, 36'h000000777); idle_n(5);
    chk("t3_intr", 64'(nxINTR), 64'h3);
    chk("t3_addr", 64'(nxADDR), 64'h200000400);
    chk("t3_cnt",  64'(nxCOUNT), 64'd2);
    step(0, 0, 0, '0, 0, 2'b01, 0); idle_n(1);
    chk("t3_clr", 64'(nxINTR), 64'h2);
    // 4: ack at t+TIMEOUT, ack at t+TIMEOUT+1, same-cycle req/ack
    req(0, 36'h1); idle_n(3); step(0, 0, 0, '0, 1, '0, 0); idle_n(1);
    chk("t4_edge_ok", 64'(nxINTR), 64'h2);
    req(0, 36'h2); idle_n(4); step(0, 0, 0, '0, 1, '0, 0);
    chk("t4_late_intr", 64'(nxINTR), 64'h3);
    idle_n(1);
    req(1, 36'h3);
    step(0, 1, 1, 36'h4, 1, '0, 0); idle_n(1);
    // 5: saturate, and clear coincident with set
    req(0, 36'h5); idle_n(3); step(0, 0, 0, '0, 0, 2'b11, 0); idle_n(1);
    chk("t5_sat", 64'(nxCOUNT), 64'd3);
    chk("t5_setwins", 64'(nxINTR), 64'h1);
    req(1, 36'h6); idle_n(3); step(0, 0, 0, '0, 0, '0, 1); idle_n(1);
    chk("cc_cnt",  64'(nxCOUNT), 64'd1);
    chk("cc_addr", 64'(nxADDR), 64'h6);
    // 6: reset at t+2 of a pending request
    req(0, 36'h7); idle_n(1); step(1, 0, 0, '0, 0, '0, 0); idle_n(6);
    chk("t6_intr", 64'(nxINTR), 64'd0);
    chk("t6_cnt",  64'(nxCOUNT), 64'd0);

    for (int i = 0; i < 800; i++) begin
      rnd = {$urandom, $urandom};
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 1)),
           rnd[ADDR_W-1:0], ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
           ($urandom_range(0, 29) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
